// File: rtl/game_ctrl_if.sv
// Signal bundle between the frogger top level and game_ctrl: per-frame tick,
// d-pad, collision/crossing flags in; game state, lives, score and audio pulses out.
interface game_ctrl_if;
  logic        frame_tick;
  logic [3:0]  dpad_input;
  logic        collision;
  logic        reached_end;
  logic [1:0]  state;
  logic        frog_reset;
  logic [2:0]  lives;
  logic [7:0]  score;
  logic        win_pulse;
  logic        lose_pulse;
  logic [10:0] time_left;

  modport master (
    output frame_tick, dpad_input, collision, reached_end,
    input  state, frog_reset, lives, score, win_pulse, lose_pulse, time_left
  );

  modport slave (
    input  frame_tick, dpad_input, collision, reached_end,
    output state, frog_reset, lives, score, win_pulse, lose_pulse, time_left
  );
endinterface

// File: rtl/game_ctrl.sv
// Frogger game-flow FSM (IDLE/PLAY/DYING/OVER) with lives, score and win/lose pulses.
// Optional per-crossing round timer enabled by macro GAME_CTRL_ROUND_TIMER_EN.
module game_ctrl #(
  parameter int START_LIVES       = 3,
  parameter int DEATH_FRAMES      = 60,
  parameter int TIME_LIMIT_FRAMES = 1800
) (
  input  logic      clk,
  input  logic      reset_n,
  game_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_DYING = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  localparam int               CNT_W      = $clog2(DEATH_FRAMES + 1);
  localparam logic [2:0]       LIVES_INIT = 3'(START_LIVES);
  localparam logic [CNT_W-1:0] CNT_END    = CNT_W'(DEATH_FRAMES);
  localparam logic [10:0]      TIME_INIT  = 11'(TIME_LIMIT_FRAMES);

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_lives, w_lives_nxt;
  logic [7:0]       r_score, w_score_nxt;
  logic             r_frog_reset, w_frog_nxt;
  logic             r_win_pulse, w_win_nxt;
  logic             r_lose_pulse, w_lose_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [3:0]       r_dpad_prev;
  logic             w_start;
  logic             w_load_timer;
  logic             w_timeout;

  // Next-state, counters and output values for the game-flow FSM
  always_comb begin
    w_start      = |(bus.dpad_input & ~r_dpad_prev);
    w_cnt_inc    = r_cnt + CNT_W'(1);
    w_state_nxt  = r_state;
    w_lives_nxt  = r_lives;
    w_score_nxt  = r_score;
    w_frog_nxt   = r_frog_reset;
    w_win_nxt    = 1'b0;
    w_lose_nxt   = 1'b0;
    w_cnt_nxt    = r_cnt;
    w_load_timer = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_frog_nxt = 1'b1;
        if (w_start) begin
          w_state_nxt  = S_PLAY;
          w_frog_nxt   = 1'b0;
          w_load_timer = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PLAY: begin
        w_frog_nxt = 1'b0;
        if (bus.collision || w_timeout) begin
          w_state_nxt = S_DYING;
          w_lives_nxt = (r_lives == 3'd0) ? 3'd0 : r_lives - 3'd1;
          w_lose_nxt  = 1'b1;
          w_frog_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end else if (bus.reached_end && !r_win_pulse) begin
          // A win pulse masks reached_end for one cycle so a lingering level scores once
          w_score_nxt  = (r_score == 8'd255) ? r_score : r_score + 8'd1;
          w_win_nxt    = 1'b1;
          w_frog_nxt   = 1'b1;
          w_load_timer = 1'b1;
        end else begin
          w_state_nxt = S_PLAY;
        end
      end
      S_DYING: begin
        w_frog_nxt = 1'b1;
        if (bus.frame_tick) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CNT_END) begin
            if (r_lives == 3'd0) begin
              w_state_nxt = S_OVER;
            end else begin
              w_state_nxt  = S_PLAY;
              w_frog_nxt   = 1'b0;
              w_load_timer = 1'b1;
            end
          end else begin
            w_state_nxt = S_DYING;
          end
        end else begin
          w_state_nxt = S_DYING;
        end
      end
      S_OVER: begin
        w_frog_nxt = 1'b1;
        if (w_start) begin
          w_state_nxt = S_IDLE;
          w_lives_nxt = LIVES_INIT;
          w_score_nxt = 8'd0;
        end else begin
          w_state_nxt = S_OVER;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_frog_nxt  = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_lives      <= LIVES_INIT;
      r_score      <= 8'd0;
      r_frog_reset <= 1'b1;
      r_win_pulse  <= 1'b0;
      r_lose_pulse <= 1'b0;
      r_cnt        <= '0;
      r_dpad_prev  <= 4'b1111;
    end else begin
      r_state      <= w_state_nxt;
      r_lives      <= w_lives_nxt;
      r_score      <= w_score_nxt;
      r_frog_reset <= w_frog_nxt;
      r_win_pulse  <= w_win_nxt;
      r_lose_pulse <= w_lose_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dpad_prev  <= bus.dpad_input;
    end
  end

`ifdef GAME_CTRL_ROUND_TIMER_EN
  logic [10:0] r_time_left, w_time_nxt;

  // Round timer: reload on PLAY entry or win, count frames down while playing
  always_comb begin
    w_timeout  = (r_state == S_PLAY) && bus.frame_tick && (r_time_left == 11'd1);
    w_time_nxt = r_time_left;
    if (w_load_timer) begin
      w_time_nxt = TIME_INIT;
    end else if ((r_state == S_PLAY) && bus.frame_tick && (r_time_left != 11'd0)) begin
      w_time_nxt = r_time_left - 11'd1;
    end else begin
      w_time_nxt = r_time_left;
    end
  end

  // Round timer register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_time_left <= 11'd0;
    end else begin
      r_time_left <= w_time_nxt;
    end
  end

  assign bus.time_left = r_time_left;
`else
  logic w_unused;
  assign w_unused      = ^{w_load_timer, TIME_INIT};
  assign w_timeout     = 1'b0;
  assign bus.time_left = 11'd0;
`endif

  assign bus.state      = r_state;
  assign bus.frog_reset = r_frog_reset;
  assign bus.lives      = r_lives;
  assign bus.score      = r_score;
  assign bus.win_pulse  = r_win_pulse;
  assign bus.lose_pulse = r_lose_pulse;
endmodule

// File: doc/game_ctrl.md
Name:
game_ctrl

Overview:
- Game-flow controller for the frogger top level.
- Consumes the frog/car overlap flag (`collision`) and the frog's `reached_end` flag, plus the d-pad and a per-frame tick.
- Produces the 2-bit `state` consumed by the frog, the frog reset request, lives/score, and one-cycle win/lose pulses for the audio block.
- Replaces the constant state and the tied-off reset in the top level.

Parameters:
- START_LIVES, 3, lives loaded at reset and on new game (1..7).
- DEATH_FRAMES, 60, frame ticks spent in DYING before respawn or game over (>=1).
- TIME_LIMIT_FRAMES, 1800, per-crossing time budget in frame ticks; used only with ROUND_TIMER_EN (<=2047).

Ports:
- clk  in  1  system clock (25.1 MHz pixel clock)
- reset_n  in  1  synchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame (start of VSYNC)
- dpad_input  in  4  {right, up, down, left}, active-high, already synchronised
- collision  in  1  frog overlaps a car (level)
- reached_end  in  1  frog reached the far side (level)
- state  out  2  00 IDLE, 01 PLAY, 10 DYING, 11 OVER
- frog_reset  out  1  high: frog forced back to its start position
- lives  out  3  remaining lives
- score  out  8  completed crossings, saturating
- win_pulse  out  1  one-cycle pulse per crossing
- lose_pulse  out  1  one-cycle pulse per death
- time_left  out  11  frames remaining in the current crossing

Behaviour:
- All outputs are registered. Every transition takes effect on the clock edge after the input is sampled high.
- Reset (reset_n=0 at a clock edge, any state, including mid-DYING):
  - state=IDLE, lives=START_LIVES, score=0, frog_reset=1, win_pulse=0, lose_pulse=0, frame counter=0, time_left=0.
- Start detect:
  - `dpad_prev` is a register of `dpad_input`.
  - start = |(dpad_input & ~dpad_prev).
  - `dpad_prev` resets to 4'b1111, so buttons held through reset never start a game.
- IDLE:
  - frog_reset=1.
  - On start: go to PLAY, frog_reset=0.
- PLAY:
  - frog_reset=0, except as noted below.
  - collision=1: go to DYING, lives<=lives-1 (held at 0 if already 0), lose_pulse=1 for one cycle, frog_reset=1.
  - Otherwise reached_end=1: stay in PLAY, score<=score+1 (saturate at 255), win_pulse=1 for one cycle, frog_reset=1 for exactly one cycle.
  - reached_end is ignored on the cycle after a win pulse, so a level held for one extra cycle scores only once.
  - collision and reached_end high on the same cycle: collision wins; no score change.
- DYING:
  - frog_reset=1.
  - The frame counter clears on entry and increments on each frame_tick.
  - When a frame_tick brings the count to DEATH_FRAMES: go to OVER if lives==0, else go to PLAY.
  - collision, reached_end and dpad_input are ignored.
- OVER:
  - frog_reset=1.
  - On start: go to IDLE, reload lives=START_LIVES, clear score.
- Pulse rules:
  - win_pulse and lose_pulse are never high in the same cycle.
  - Each is high for exactly one clock.
- Counters: the frame counter is wide enough for DEATH_FRAMES. frame_tick outside DYING (and outside PLAY when the timer is enabled) has no effect.

Optional Feature:
- Macro: GAME_CTRL_ROUND_TIMER_EN.
- Defined:
  - time_left loads TIME_LIMIT_FRAMES on entry to PLAY and on every win.
  - In PLAY it decrements on each frame_tick.
  - A frame_tick that brings it from 1 to 0 is treated exactly as a collision on that cycle: DYING, lives-1, lose_pulse.
  - Holds its value outside PLAY.
- Not defined:
  - time_left is constant 0 and has no effect on transitions.
  - No timer logic is synthesised.

Test Plan:
- Reset with dpad_input=4'b0100 held, then held another 10 cycles -> state stays 00, frog_reset=1, lives=3, score=0. Release, then press up -> state=01 one cycle after the edge, frog_reset=0.
- In PLAY, reached_end high for 2 cycles, three times -> score=3, three single-cycle win_pulse, three single-cycle frog_reset pulses, state stays 01.
- DEATH_FRAMES=4: collision in PLAY -> state=10, lives 3->2, single lose_pulse. After the 4th frame_tick -> state=01. collision during DYING -> no further lives change.
- START_LIVES=1: collision -> lives=0, DYING, then OVER after DEATH_FRAMES ticks. Press left -> IDLE, lives=1, score=0.
- collision and reached_end asserted on the same cycle with score=5 -> DYING, score stays 5, lose_pulse=1, win_pulse=0. Assert reset_n=0 mid-DYING -> all reset values next cycle.
- With GAME_CTRL_ROUND_TIMER_EN and TIME_LIMIT_FRAMES=3: enter PLAY -> time_left=3. After 3 frame_ticks -> state=10, lives-1. Without the macro, 3 frame_ticks -> time_left=0 and state stays 01.
